// File: rtl/instr_cache.sv
// Direct-mapped instruction cache: 16-byte blocks, combinational hit path, block refill over a read/busywait handshake.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module instr_cache #(
    parameter int ADDR_BITS   = 10,
    parameter int INDEX_BITS  = 3,
    parameter int OFFSET_BITS = 4
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic [31:0]                      PC,
    output logic [31:0]                      INSTRUCTION,
    output logic                             BUSYWAIT,
    output logic                             MEM_READ,
    output logic [ADDR_BITS-OFFSET_BITS-1:0] MEM_ADDRESS,
    input  logic [127:0]                     MEM_READDATA,
    input  logic                             MEM_BUSYWAIT,
    output logic [15:0]                      HIT_COUNT,
    output logic [15:0]                      MISS_COUNT
);

    localparam int BLK_BITS = ADDR_BITS - OFFSET_BITS;
    localparam int TAG_BITS = BLK_BITS - INDEX_BITS;
    localparam int NUM_BLKS = 1 << INDEX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_UPDATE} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [NUM_BLKS-1:0]   r_valid;
    logic [TAG_BITS-1:0]   r_tag  [NUM_BLKS];
    logic [127:0]          r_data [NUM_BLKS];
    logic [BLK_BITS-1:0]   r_blk_addr;

    logic [INDEX_BITS-1:0] w_pc_index;
    logic [TAG_BITS-1:0]   w_pc_tag;
    logic [BLK_BITS-1:0]   w_pc_blk;
    logic [INDEX_BITS-1:0] w_fill_index;
    logic [TAG_BITS-1:0]   w_fill_tag;
    logic [127:0]          w_block;
    logic                  w_hit;
    logic                  w_fill_done;
    logic                  w_unused_pc;

    assign w_pc_index   = PC[OFFSET_BITS +: INDEX_BITS];
    assign w_pc_tag     = PC[OFFSET_BITS+INDEX_BITS +: TAG_BITS];
    assign w_pc_blk     = PC[OFFSET_BITS +: BLK_BITS];
    assign w_fill_index = r_blk_addr[INDEX_BITS-1:0];
    assign w_fill_tag   = r_blk_addr[BLK_BITS-1:INDEX_BITS];
    assign w_unused_pc  = ^{PC[31:ADDR_BITS], PC[1:0]};

    assign w_block     = r_data[w_pc_index];
    assign w_hit       = r_valid[w_pc_index] && (r_tag[w_pc_index] == w_pc_tag);
    assign w_fill_done = (r_state == S_FETCH) && !MEM_BUSYWAIT;
    assign MEM_ADDRESS = r_blk_addr;

    // Gated by hit so a never-filled (unreset) line cannot leak X onto the fetch bus.
    assign INSTRUCTION = w_hit ? w_block[{PC[3:2], 5'd0} +: 32] : 32'd0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_blk_addr <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && !w_hit)
                r_blk_addr <= w_pc_blk;
            if (w_fill_done)
                r_valid[w_fill_index] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays have no reset; the valid bits alone decide whether their contents matter.
    always_ff @(posedge CLK) begin
        if (RESET && w_fill_done) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= MEM_READDATA;
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        BUSYWAIT     = 1'b0;
        MEM_READ     = 1'b0;
        case (r_state)
            S_IDLE: begin
                BUSYWAIT = !w_hit;
                if (!w_hit)
                    w_next_state = S_FETCH;
            end
            S_FETCH: begin
                BUSYWAIT = 1'b1;
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT)
                    w_next_state = S_UPDATE;
            end
            S_UPDATE: begin
                BUSYWAIT     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
        // The CPU is never stalled while reset is asserted, whatever state is about to be cleared.
        if (!RESET)
            BUSYWAIT = 1'b0;
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_hit && r_hit_count != 16'hFFFF)
                r_hit_count <= r_hit_count + 16'd1;
            if (!w_hit && r_miss_count != 16'hFFFF)
                r_miss_count <= r_miss_count + 16'd1;
        end
    end

    assign HIT_COUNT  = r_hit_count;
    assign MISS_COUNT = r_miss_count;
`else
    assign HIT_COUNT  = 16'd0;
    assign MISS_COUNT = 16'd0;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Bench for instr_cache: directed scenarios plus a randomized fetch stream scored against a block-level cache model.
// Counter expectations follow ICACHE_STATS_EN as seen by this file.
module tb_instr_cache;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [31:0]  PC = 32'd0;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
    logic [15:0]  HIT_COUNT;
    logic [15:0]  MISS_COUNT;

    instr_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT),
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 25)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Block memory: busy for lat_cfg cycles after MEM_READ rises, then presents the block.
    logic [127:0] mem [64];
    int           lat_cfg = 4;
    int           mem_cnt = 0;
    logic [127:0] junk = '0;

    always @(posedge CLK) begin
        mem_cnt <= MEM_READ ? mem_cnt + 1 : 0;
        junk    <= {$urandom, $urandom, $urandom, $urandom};
    end
    assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < lat_cfg);
    assign MEM_READDATA = MEM_BUSYWAIT ? junk : mem[MEM_ADDRESS];

    // Scoreboard: one entry per fetch, popped when the CPU is released.
    typedef struct {
        logic [31:0] instr;
        int          stalls;
        int          miss;
        logic [5:0]  blk;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       e;
    bit         sb_en = 0;
    int         busy_cnt = 0;
    int         rd_cnt = 0;
    logic [5:0] rd_addr = '0;
    logic       prev_mr = 1'b0;

    always @(negedge CLK) begin
        if (sb_en) begin
            if (MEM_READ && !prev_mr) begin
                rd_cnt++;
                rd_addr = MEM_ADDRESS;
            end
            if (BUSYWAIT)
                busy_cnt++;
            else begin
                check("sb_queue_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sb_instr", INSTRUCTION, e.instr);
                    check("sb_stall_cycles", busy_cnt, e.stalls);
                    check("sb_mem_reads", rd_cnt, e.miss);
                    if (e.miss != 0)
                        check("sb_mem_address", rd_addr, e.blk);
                end
                busy_cnt = 0;
                rd_cnt   = 0;
            end
        end
        prev_mr = MEM_READ;
    end

    // Counter model from visible behaviour: a released IDLE cycle is a hit, a stall that is
    // neither a memory read nor the cycle right after a live read is an IDLE miss.
    logic [15:0] exp_h = '0;
    logic [15:0] exp_m = '0;
    bit          stats_en = 0;
    logic        prev_live = 1'b0;

    always @(negedge CLK) begin
        if (stats_en) begin
`ifdef ICACHE_STATS_EN
            check("hit_count", HIT_COUNT, exp_h);
            check("miss_count", MISS_COUNT, exp_m);
`else
            check("hit_count_off", HIT_COUNT, 0);
            check("miss_count_off", MISS_COUNT, 0);
`endif
            if (!RESET) begin
                exp_h = '0;
                exp_m = '0;
            end else begin
                if (!BUSYWAIT && exp_h != 16'hFFFF)
                    exp_h++;
                if (BUSYWAIT && !MEM_READ && !prev_live && exp_m != 16'hFFFF)
                    exp_m++;
            end
        end
        prev_live = MEM_READ && RESET;
    end

    task automatic do_reset();
        RESET = 1'b0;
        @(posedge CLK);
        #1 stats_en = 1;
        @(negedge CLK);
        check("rst_busywait", BUSYWAIT, 0);
        check("rst_mem_read", MEM_READ, 0);
        check("rst_mem_address", MEM_ADDRESS, 0);
        @(posedge CLK);
        #1 RESET = 1'b1;
    endtask

    // Issues one fetch and returns once the CPU is released (at a negedge).
    task automatic do_fetch(input logic [31:0] pc, input bit sw, input logic [31:0] pc2,
                            output int stalls, output int reads,
                            output logic [5:0] a0, output logic [5:0] a1);
        logic pmr;
        int   budget;
        PC = pc; stalls = 0; reads = 0; a0 = '0; a1 = '0; pmr = 1'b0; budget = 0;
        @(negedge CLK);
        while (BUSYWAIT && budget < 200) begin
            if (MEM_READ && !pmr) begin
                if (reads == 0) a0 = MEM_ADDRESS;
                else            a1 = MEM_ADDRESS;
                reads++;
                if (sw && reads == 1)
                    PC = pc2;
            end
            pmr = MEM_READ;
            stalls++;
            budget++;
            @(negedge CLK);
        end
        check("fetch_released", BUSYWAIT, 0);
    endtask

    function automatic logic [31:0] word_of(input logic [5:0] blk, input logic [1:0] w);
        logic [127:0] b;
        b = mem[blk];
        return b[{w, 5'd0} +: 32];
    endfunction

    int         st, rd, budget;
    logic [5:0] a0, a1;
    logic       mval [8];
    logic [2:0] mtag [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++)
            mem[i] = {$urandom, $urandom, $urandom, $urandom};
        @(posedge CLK);
        #1;
        do_reset();

        // Cold miss with a 4-cycle memory.
        lat_cfg = 4;
        do_fetch(32'd0, 0, 32'd0, st, rd, a0, a1);
        check("cold_stalls", st, 7);
        check("cold_reads", rd, 1);
        check("cold_mem_address", a0, 0);
        check("cold_instr", INSTRUCTION, word_of(6'd0, 2'd0));

        // Spatial hits on consecutive cycles.
        for (int w = 1; w < 4; w++) begin
            @(posedge CLK);
            #1;
            do_fetch(32'(w * 4), 0, 32'd0, st, rd, a0, a1);
            check("spatial_stalls", st, 0);
            check("spatial_reads", rd, 0);
            check("spatial_instr", INSTRUCTION, word_of(6'd0, 2'(w)));
        end
`ifdef ICACHE_STATS_EN
        check("stats_hits_after_cold", HIT_COUNT, 3);
        check("stats_misses_after_cold", MISS_COUNT, 1);
`else
        check("stats_hits_off", HIT_COUNT, 0);
        check("stats_misses_off", MISS_COUNT, 0);
`endif

        // Conflict miss on index 0, then back; upper PC bits must be ignored.
        @(posedge CLK); #1;
        do_fetch(32'd128, 0, 32'd0, st, rd, a0, a1);
        check("conflict_stalls", st, 7);
        check("conflict_mem_address", a0, 8);
        check("conflict_instr", INSTRUCTION, word_of(6'd8, 2'd0));
        @(posedge CLK); #1;
        do_fetch(32'd0, 0, 32'd0, st, rd, a0, a1);
        check("conflict_back_mem_address", a0, 0);
        check("conflict_back_reads", rd, 1);
        check("conflict_back_instr", INSTRUCTION, word_of(6'd0, 2'd0));
        @(posedge CLK); #1;
        do_fetch(32'hABCD_E008, 0, 32'd0, st, rd, a0, a1);
        check("high_pc_bits_reads", rd, 0);
        check("high_pc_bits_instr", INSTRUCTION, word_of(6'd0, 2'd2));

        // PC changes during FETCH: block 1 completes, then PC=32 misses on its own.
        @(posedge CLK); #1;
        do_fetch(32'd16, 1, 32'd32, st, rd, a0, a1);
        check("pcswitch_reads", rd, 2);
        check("pcswitch_first_address", a0, 1);
        check("pcswitch_second_address", a1, 2);
        check("pcswitch_stalls", st, 14);
        check("pcswitch_instr", INSTRUCTION, word_of(6'd2, 2'd0));
        @(posedge CLK); #1;
        do_fetch(32'd20, 0, 32'd0, st, rd, a0, a1);
        check("pcswitch_block1_valid", rd, 0);
        check("pcswitch_block1_instr", INSTRUCTION, word_of(6'd1, 2'd1));

        // Reset during the second FETCH cycle.
        @(posedge CLK); #1;
        lat_cfg = 10;
        PC = 32'd64;
        budget = 0;
        @(negedge CLK);
        while (!MEM_READ && budget < 20) begin
            budget++;
            @(negedge CLK);
        end
        check("rstfetch_started", MEM_READ, 1);
        @(posedge CLK); #1;
        RESET = 1'b0;
        PC = 32'd0;
        @(negedge CLK);
        check("rstfetch_busywait_low", BUSYWAIT, 0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rstfetch_mem_read_dropped", MEM_READ, 0);
        check("rstfetch_mem_address", MEM_ADDRESS, 0);
        check("rstfetch_busywait_held", BUSYWAIT, 0);
        lat_cfg = 2;
        @(posedge CLK); #1;
        RESET = 1'b1;
        do_fetch(32'd0, 0, 32'd0, st, rd, a0, a1);
        check("rstfetch_refetch_reads", rd, 1);
        check("rstfetch_refetch_stalls", st, 5);
        check("rstfetch_refetch_instr", INSTRUCTION, word_of(6'd0, 2'd0));
        @(posedge CLK); #1;
        do_fetch(32'd32, 0, 32'd0, st, rd, a0, a1);
        check("rstfetch_block2_invalid", rd, 1);

        // Randomized fetch stream against a block-level model.
        @(posedge CLK); #1;
        do_reset();
        for (int i = 0; i < 8; i++) mval[i] = 1'b0;
        sb_en = 1;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] pc;
            logic [5:0]  blk;
            exp_t        x;
            int          lat;
            bit          hit;
            pc       = $urandom;
            pc[9:2]  = 8'($urandom_range(0, 95));
            blk      = pc[9:4];
            hit      = mval[blk[2:0]] && (mtag[blk[2:0]] == blk[5:3]);
            lat      = $urandom_range(1, 5);
            x.instr  = word_of(blk, pc[3:2]);
            x.stalls = hit ? 0 : lat + 3;
            x.miss   = hit ? 0 : 1;
            x.blk    = blk;
            sb_q.push_back(x);
            mval[blk[2:0]] = 1'b1;
            mtag[blk[2:0]] = blk[5:3];
            lat_cfg = lat;
            PC = pc;
            budget = 0;
            @(negedge CLK);
            while (BUSYWAIT && budget < 100) begin
                budget++;
                @(negedge CLK);
            end
            @(posedge CLK); #1;
        end
        sb_en = 0;
        check("sb_drained", sb_q.size(), 0);

        @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_cache.md
Name: instr_cache

Overview:
Direct-mapped instruction cache between the CPU fetch port (PC in, INSTRUCTION out) and a slow block-wide instruction memory.
- Hits return the addressed word combinationally.
- Misses stall the CPU via BUSYWAIT while a 16-byte block is fetched over a read/busywait handshake.
- Replaces the zero-wait combinational instruction array in front of the CPU.

Parameters:
ADDR_BITS, 10, significant PC bits (byte address; 1 KB instruction space)
INDEX_BITS, 3, cache index width (2^INDEX_BITS blocks)
OFFSET_BITS, 4, byte offset within block (fixed at 4: 16-byte blocks, 4 words)

Ports:
CLK  input  1  single system clock, all state updates on rising edge
RESET  input  1  synchronous, active-low reset
PC  input  32  CPU fetch address; bits [ADDR_BITS-1:0] used, [1:0] ignored
INSTRUCTION  output  32  instruction word for PC (valid when BUSYWAIT=0)
BUSYWAIT  output  1  stall to CPU
MEM_READ  output  1  block read request to instruction memory
MEM_ADDRESS  output  ADDR_BITS-OFFSET_BITS  block address (PC[ADDR_BITS-1:4])
MEM_READDATA  input  128  block data; word0 in [31:0] … word3 in [127:96]
MEM_BUSYWAIT  input  1  memory busy; must go high with MEM_READ and stay high until data valid
HIT_COUNT  output  16  hit counter (see Optional Feature)
MISS_COUNT  output  16  miss counter (see Optional Feature)

Behaviour:
- Address split:
  - offset word = PC[3:2]
  - index = PC[4+INDEX_BITS-1:4]
  - tag = PC[ADDR_BITS-1:4+INDEX_BITS]
  - defaults give a 3-bit index and a 3-bit tag
- Storage per block: valid bit, tag, 128-bit data.
- Hit = valid[index] && tag[index]==tag(PC); combinational.
- INSTRUCTION = data[index] word selected by PC[3:2]; combinational. Value is don't-care while BUSYWAIT=1.
- State machine: IDLE, FETCH, UPDATE.
  - IDLE:
    - BUSYWAIT = !hit.
    - On miss, latch block address PC[ADDR_BITS-1:4] and go to FETCH at next edge.
  - FETCH:
    - MEM_READ=1, MEM_ADDRESS=latched address, BUSYWAIT=1.
    - On first edge with MEM_BUSYWAIT=0: write MEM_READDATA to data[latched index], set tag, set valid=1, go to UPDATE.
  - UPDATE:
    - BUSYWAIT=1, MEM_READ=0; one cycle only, then IDLE.
    - On return to IDLE, hit is re-evaluated against the current PC.
- PC changing during FETCH/UPDATE: the in-flight fetch completes for the latched address. The new PC is evaluated in IDLE and may miss again.
- Miss penalty = 1 (IDLE detect) + FETCH cycles + 1 (UPDATE).
- Replacement: unconditional overwrite of the indexed block; no dirty state (read-only cache).
- Reset (RESET=0 at a rising edge), including mid-operation:
  - all valid bits cleared; state=IDLE
  - MEM_READ=0 from that edge; memory data arriving afterwards ignored; no array write
  - while RESET=0, BUSYWAIT held 0
  - MEM_ADDRESS=0, counters=0
- Tag and data arrays are not reset; only valid bits.
- No X on outputs after first reset edge.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - HIT_COUNT increments once per IDLE cycle with hit=1 and RESET=1.
  - MISS_COUNT increments once per IDLE→FETCH transition.
  - Both 16-bit, saturate at 16'hFFFF, cleared by reset.
- Not defined: HIT_COUNT and MISS_COUNT tied to 0; no counter flops.

Test Plan:
- Cold miss:
  - Stimulus: reset, PC=0; memory model holds MEM_BUSYWAIT high 4 cycles after MEM_READ then low.
  - Response: BUSYWAIT high for 7 cycles, MEM_ADDRESS=0; then BUSYWAIT=0, INSTRUCTION=MEM_READDATA[31:0].
- Spatial hits: after the cold miss, PC=4,8,12 on consecutive cycles → BUSYWAIT=0 each cycle, INSTRUCTION = words 1,2,3, no MEM_READ.
- Conflict miss:
  - Stimulus: PC=0 then PC=128 (same index 0, tag 1), then PC=0.
  - Response: each causes a miss with MEM_ADDRESS=8 then 0; data replaced correctly each time.
- PC change during fetch: PC=16 miss, switch PC to 32 mid-FETCH → block 1 filled (valid[1]=1), then a new miss with MEM_ADDRESS=2.
- Reset mid-fetch:
  - Stimulus: RESET=0 during the 2nd FETCH cycle, released 2 cycles later, PC=0.
  - Response: MEM_READ drops at the reset edge, BUSYWAIT=0 during reset, block 0 invalid → fresh miss on release.
- ICACHE_STATS_EN: cold miss + 3 hits → HIT_COUNT=3 (plus hit cycles after fill), MISS_COUNT=1; without macro both read 0.
